// File: rtl/nmea_pkg.sv
// nmea_pkg: shared character constants, error codes, FSM encoding and hex decode for the NMEA feed path
package nmea_pkg;

    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_LF     = 8'h0A;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_CKSUM   = 3'd1;
    localparam logic [2:0] ERR_LEN     = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_HEX     = 3'd4;
    localparam logic [2:0] ERR_RESYNC  = 3'd5;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_BODY,
        ST_CK_HI,
        ST_CK_LO,
        ST_EOL,
        ST_DONE
    } state_t;

    // {ok, nibble}; only uppercase hex digits are legal in an NMEA checksum
    function automatic logic [4:0] hex2nib(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) ? {1'b1, c[3:0]} :
               (c >= 8'h41 && c <= 8'h46) ? {1'b1, c[3:0] + 4'd9} : 5'd0;
    endfunction

endpackage

// File: rtl/nmea_byte_fifo.sv
// nmea_byte_fifo: byte FIFO with combinational head read so a pop can be acted on in the same cycle
module nmea_byte_fifo
#(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wp;
    logic [AW:0] rp;

    assign empty = wp == rp;
    assign full  = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
    assign dout  = mem[rp[AW-1:0]];

    // read/write pointers with a wrap bit to tell full from empty
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
        end
    end

    // storage array, no reset needed since pointers define validity
    always_ff @(posedge clk) begin
        if (push) mem[wp[AW-1:0]] <= din;
    end

endmodule

// File: rtl/nmea_feed_ctrl.sv
// nmea_feed_ctrl: buffers UART bytes, forwards one NMEA sentence at a time to nmea_parse with pacing and a per-frame verdict; define NMEA_CKSUM_EN to check the '*hh' checksum
module nmea_feed_ctrl
    import nmea_pkg::*;
#(
    parameter int FIFO_DEPTH     = 16,
    parameter int GAP_CYCLES     = 2,
    parameter int MAX_LEN        = 82,
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] char,
    output logic       valid,
    output logic       frame_done,
    output logic       frame_ok,
    output logic [2:0] err_code,
    output logic       overflow,
    output logic       busy
);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int LW = $clog2(MAX_LEN + 2);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 2);

    state_t        state;
    logic [7:0]    b;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          active;
    logic          over;
    logic          tmo;
    logic          fwd;
    logic          err_hit;
    logic [2:0]    err_n;
    logic [GW-1:0] gap;
    logic [LW-1:0] len;
    logic [TW-1:0] timer;
`ifdef NMEA_CKSUM_EN
    logic [7:0]    cks;
    logic [3:0]    hi;
    logic [3:0]    lo;
    logic [4:0]    hx;
`endif

    // a pop in the same cycle frees the slot, so a byte arriving on a full FIFO is still taken
    assign push   = rx_valid && (!full || pop);
    assign pop    = !empty && gap == '0 && state != ST_DONE;
    assign busy   = state != ST_HUNT || !empty;
    assign active = state != ST_HUNT && state != ST_DONE;
    // a '$' inside the body restarts the frame, so it is exempt from the length limit
    assign over   = active && !(state == ST_BODY && b == CH_DOLLAR) && len >= LW'(MAX_LEN);
    assign tmo    = TIMEOUT_CYCLES != 0 && active && empty && timer == TW'(TIMEOUT_CYCLES - 1);
    assign fwd    = pop && (state == ST_HUNT ? b == CH_DOLLAR : !over);

    nmea_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (rx_data),
        .dout  (b),
        .full  (full),
        .empty (empty)
    );

    // classify the popped byte (or idle timeout) into the first error of the frame
    always_comb begin
        err_hit = 1'b0;
        err_n   = ERR_NONE;
`ifdef NMEA_CKSUM_EN
        hx      = hex2nib(b);
`endif
        if (tmo) begin
            err_hit = 1'b1;
            err_n   = ERR_TIMEOUT;
        end else if (pop && active) begin
            if (over) begin
                err_hit = 1'b1;
                err_n   = ERR_LEN;
            end else if (state == ST_BODY && b == CH_DOLLAR) begin
                err_hit = 1'b1;
                err_n   = ERR_RESYNC;
            end
`ifdef NMEA_CKSUM_EN
            else if ((state == ST_CK_HI || state == ST_CK_LO) && !hx[4]) begin
                err_hit = 1'b1;
                err_n   = ERR_HEX;
            end else if (state == ST_EOL && b != CH_CR && b != CH_LF) begin
                err_hit = 1'b1;
                err_n   = ERR_HEX;
            end
`endif
        end
    end

    // sentence FSM with registered char/valid and verdict outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_HUNT;
            char       <= '0;
            valid      <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            err_code   <= ERR_NONE;
            len        <= '0;
`ifdef NMEA_CKSUM_EN
            cks        <= '0;
            hi         <= '0;
            lo         <= '0;
`endif
        end else begin
            valid      <= fwd;
            frame_done <= 1'b0;
            if (fwd) char <= b;
            if (err_hit) begin
                frame_done <= 1'b1;
                frame_ok   <= 1'b0;
                err_code   <= err_n;
                state      <= err_n == ERR_RESYNC ? ST_BODY : ST_HUNT;
                len        <= LW'(1);
`ifdef NMEA_CKSUM_EN
                cks        <= '0;
`endif
            end else if (pop) begin
                case (state)
                    ST_HUNT: begin
                        if (b == CH_DOLLAR) begin
                            state <= ST_BODY;
                            len   <= LW'(1);
`ifdef NMEA_CKSUM_EN
                            cks   <= '0;
`endif
                        end
                    end
                    ST_BODY: begin
                        len <= len + 1'b1;
                        if (b == CH_STAR) state <= ST_CK_HI;
`ifdef NMEA_CKSUM_EN
                        else cks <= cks ^ b;
`endif
                    end
                    ST_CK_HI: begin
                        len   <= len + 1'b1;
                        state <= ST_CK_LO;
`ifdef NMEA_CKSUM_EN
                        hi    <= hx[3:0];
`endif
                    end
                    ST_CK_LO: begin
                        len   <= len + 1'b1;
                        state <= ST_EOL;
`ifdef NMEA_CKSUM_EN
                        lo    <= hx[3:0];
`endif
                    end
                    ST_EOL: begin
                        len <= len + 1'b1;
                        if (b == CH_LF) begin
                            state      <= ST_DONE;
                            frame_done <= 1'b1;
`ifdef NMEA_CKSUM_EN
                            frame_ok   <= {hi, lo} == cks;
                            err_code   <= {hi, lo} == cks ? ERR_NONE : ERR_CKSUM;
`else
                            frame_ok   <= 1'b1;
                            err_code   <= ERR_NONE;
`endif
                        end
                    end
                    default: ;
                endcase
            end else if (state == ST_DONE) begin
                state <= ST_HUNT;
            end
        end
    end

    // pacing gap after each forwarded byte, in-frame idle timer and sticky overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gap      <= '0;
            timer    <= '0;
            overflow <= 1'b0;
        end else begin
            gap   <= fwd ? GW'(GAP_CYCLES) : gap != '0 ? gap - 1'b1 : gap;
            timer <= pop || !active ? '0 : timer + TW'(empty);
            if (rx_valid && full && !pop) overflow <= 1'b1;
        end
    end

endmodule
